// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store sequencer.
//   op_t    : request opcode encoding seen on the op port
//   state_t : sequencer FSM state encoding (also visible on dbg_state)
//   is_load / is_subword / misaligned : opcode classification helpers
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic is_load(input op_t op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_subword(input op_t op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

  // Words need a 4-byte aligned address, halfwords a 2-byte aligned one;
  // bytes can never be misaligned.
  function automatic logic misaligned(input op_t op, input logic [1:0] lsb);
    logic m;
    m = 1'b0;
    case (op)
      OP_LW, OP_SW:         m = (lsb != 2'b00);
      OP_LH, OP_LHU, OP_SH: m = lsb[0];
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_merge.sv
// store_merge: combinational merge of a store operand into a memory word.
// Memory is big-endian and the word starts at the access address, so the
// addressed halfword/byte always sits in the top bits of the word.
//   buf_word   : word previously read from memory (merge buffer)
//   store_data : store operand (SH uses [15:0], SB uses [7:0])
//   op         : store opcode; SW passes store_data through whole
//   merged     : word to write back
module store_merge
  import mem_pkg::*;
(
  input  logic [31:0] buf_word,
  input  logic [31:0] store_data,
  input  op_t         op,
  output logic [31:0] merged
);

  always_comb begin
    merged = buf_word;
    case (op)
      OP_SW:   merged = store_data;
      OP_SH:   merged[31:16] = store_data[15:0];
      OP_SB:   merged[31:24] = store_data[7:0];
      default: merged = buf_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store sequencer in front of a
// word-only, byte-addressed, big-endian memory. Sub-word stores are done
// as read-modify-write; misaligned requests finish with err and never
// reach memory.
// Ports:
//   clk, rst (sync, active-low)
//   req/op/address/storeData : request, sampled only while ready=1
//   ready, done, err, loadData : status and extended load result
//   memRead/memWrite/memAddress/memWriteData/memReadData : memory side
//   dbg_state : current FSM state (state_t encoding)
// Handshake: a request is taken on a rising edge where req=1 and ready=1;
// it completes with a single-cycle done pulse (err qualified by done), and
// ready is low from the accepting edge until the cycle after done.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       storeData,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       loadData,
  output logic              memRead,
  output logic              memWrite,
  output logic [31:0]       memAddress,
  output logic [31:0]       memWriteData,
  input  logic [31:0]       memReadData,
  output logic [2:0]        dbg_state
);

  state_t            state_q, state_d;
  op_t               op_q;
  op_t               op_in;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic [31:0]       buf_q;
  logic [31:0]       load_q;
  logic              err_q;
  logic              mis_in;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign op_in  = op_t'(op);
  assign mis_in = misaligned(op_in, address[1:0]);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (mis_in)                 state_d = S_DONE;
          else if (is_load(op_in))    state_d = S_LOAD;
          else if (is_subword(op_in)) state_d = S_RMW_RD;
          else                        state_d = S_STORE;
        end
      end
      S_LOAD, S_STORE, S_RMW_WR: state_d = S_DONE;
      S_RMW_RD:                  state_d = S_RMW_WR;
      S_DONE:                    state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Load extension: the addressed halfword/byte is in the top of the word.
  always_comb begin
    load_ext = memReadData;
    case (op_q)
      OP_LH:   load_ext = {{16{memReadData[31]}}, memReadData[31:16]};
      OP_LHU:  load_ext = {16'h0, memReadData[31:16]};
      OP_LB:   load_ext = {{24{memReadData[31]}}, memReadData[31:24]};
      OP_LBU:  load_ext = {24'h0, memReadData[31:24]};
      default: load_ext = memReadData;
    endcase
  end

  store_merge u_merge (
    .buf_word   (buf_q),
    .store_data (sdata_q),
    .op         (op_q),
    .merged     (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      sdata_q <= '0;
      buf_q   <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            op_q    <= op_in;
            addr_q  <= address;
            sdata_q <= storeData;
            err_q   <= mis_in;
          end
        end
        S_LOAD:   load_q <= load_ext;
        S_RMW_RD: buf_q  <= memReadData;
        S_DONE:   err_q  <= 1'b0;
        default:  ;
      endcase
    end
  end

  // Moore outputs; memWrite is additionally gated by rst so a reset
  // arriving during a write cycle kills that write immediately.
  always_comb begin
    ready        = (state_q == S_IDLE);
    done         = (state_q == S_DONE);
    err          = (state_q == S_DONE) && err_q;
    loadData     = load_q;
    memRead      = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    memWrite     = ((state_q == S_STORE) || (state_q == S_RMW_WR)) && rst;
    memAddress   = (state_q == S_IDLE) ? 32'h0 : 32'(addr_q);
    memWriteData = ((state_q == S_STORE) || (state_q == S_RMW_WR)) ? merged : 32'h0;
    dbg_state    = state_q;
  end

endmodule
